// File: rtl/matmul_sequencer.sv
// Control FSM for the N x N matrix-multiply datapath: walks (i, j, k), feeds operand
// pairs to the MAC, and forwards each finished C[i][j] to the writer in row-major order.
module matmul_sequencer #(
    parameter int N     = 8,
    parameter int IDX_W = 5,
    parameter int DW    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_rd_en,
    output logic [IDX_W-1:0] o_a_row,
    output logic [IDX_W-1:0] o_a_col,
    output logic [IDX_W-1:0] o_b_row,
    output logic [IDX_W-1:0] o_b_col,
    input  logic [DW-1:0]    i_a_data,
    input  logic [DW-1:0]    i_b_data,
    output logic [DW-1:0]    o_mac_a,
    output logic [DW-1:0]    o_mac_b,
    output logic             o_mac_first,
    output logic             o_mac_last,
    output logic             o_mac_stb,
    input  logic             i_mac_ack,
    input  logic [DW-1:0]    i_res_data,
    input  logic             i_res_stb,
    output logic             o_res_ack,
    output logic [DW-1:0]    o_out_value,
    output logic [IDX_W-1:0] o_out_i,
    output logic [IDX_W-1:0] o_out_j,
    output logic             o_out_stb,
    input  logic             i_out_ack
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_ISSUE, S_RESULT, S_OUT, S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_i, r_j, r_k;
    logic [DW-1:0]    r_mac_a, r_mac_b, r_out_value;
    logic             r_mac_first, r_mac_last;
    logic [IDX_W-1:0] r_out_i, r_out_j;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (i_start)   w_next = S_FETCH;
            S_FETCH:                       w_next = S_LOAD;
            S_LOAD:                        w_next = S_ISSUE;
            S_ISSUE:  if (i_mac_ack)       w_next = (r_k == LAST) ? S_RESULT : S_FETCH;
            S_RESULT: if (i_res_stb)       w_next = S_OUT;
            S_OUT:    if (i_out_ack)       w_next = (r_i == LAST && r_j == LAST) ? S_DONE : S_FETCH;
            default:                       w_next = S_IDLE;
        endcase
    end

    // Strobes decode straight off the state register, so they drop on the
    // same edge that completes a transfer or applies reset.
    always_comb begin
        o_busy    = (r_state != S_IDLE) && (r_state != S_DONE);
        o_done    = (r_state == S_DONE);
        o_rd_en   = (r_state == S_FETCH);
        o_mac_stb = (r_state == S_ISSUE);
        o_res_ack = (r_state == S_RESULT);
        o_out_stb = (r_state == S_OUT);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_mac_first <= 1'b0;
            r_mac_last  <= 1'b0;
            r_out_value <= '0;
            r_out_i     <= '0;
            r_out_j     <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (i_start) begin
                    r_i <= '0;
                    r_j <= '0;
                    r_k <= '0;
                end
                S_LOAD: begin
                    r_mac_a     <= i_a_data;
                    r_mac_b     <= i_b_data;
                    r_mac_first <= (r_k == '0);
                    r_mac_last  <= (r_k == LAST);
                end
                S_ISSUE: if (i_mac_ack) r_k <= (r_k == LAST) ? '0 : r_k + 1'b1;
                S_RESULT: if (i_res_stb) begin
                    r_out_value <= i_res_data;
                    r_out_i     <= r_i;
                    r_out_j     <= r_j;
                end
                S_OUT: if (i_out_ack) begin
                    // The final element leaves i, j at N-1; the next start clears them.
                    if (r_j != LAST) begin
                        r_j <= r_j + 1'b1;
                    end else if (r_i != LAST) begin
                        r_j <= '0;
                        r_i <= r_i + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_a_row     = r_i;
    assign o_a_col     = r_k;
    assign o_b_row     = r_k;
    assign o_b_col     = r_j;
    assign o_mac_a     = r_mac_a;
    assign o_mac_b     = r_mac_b;
    assign o_mac_first = r_mac_first;
    assign o_mac_last  = r_mac_last;
    assign o_out_value = r_out_value;
    assign o_out_i     = r_out_i;
    assign o_out_j     = r_out_j;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: an N=2 instance driven by operand-memory and MAC models
// with a result scoreboard, plus an N=1 instance for start/done corner cases.
module tb_matmul_sequencer;
    localparam int IW = 5;
    localparam int DW = 32;

    typedef struct { logic [DW-1:0] a, b; logic f, l; } term_t;
    typedef struct { logic [IW-1:0] i, j; logic [DW-1:0] v; } res_t;

    logic clk, rst_n;
    logic start, busy, done, rd_en;
    logic [IW-1:0] a_row, a_col, b_row, b_col, out_i, out_j;
    logic [DW-1:0] a_data, b_data, mac_a, mac_b, res_data, out_value;
    logic mac_first, mac_last, mac_stb, mac_ack, res_stb, res_ack, out_stb, out_ack;

    logic start1, busy1, done1, rd_en1;
    logic [IW-1:0] a_row1, a_col1, b_row1, b_col1, out_i1, out_j1;
    logic [DW-1:0] a_data1, b_data1, mac_a1, mac_b1, res_data1, out_value1;
    logic mac_first1, mac_last1, mac_stb1, mac_ack1, res_stb1, res_ack1, out_stb1, out_ack1;

    matmul_sequencer #(.N(2), .IDX_W(IW), .DW(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
        .o_rd_en(rd_en), .o_a_row(a_row), .o_a_col(a_col), .o_b_row(b_row), .o_b_col(b_col),
        .i_a_data(a_data), .i_b_data(b_data), .o_mac_a(mac_a), .o_mac_b(mac_b),
        .o_mac_first(mac_first), .o_mac_last(mac_last), .o_mac_stb(mac_stb), .i_mac_ack(mac_ack),
        .i_res_data(res_data), .i_res_stb(res_stb), .o_res_ack(res_ack),
        .o_out_value(out_value), .o_out_i(out_i), .o_out_j(out_j), .o_out_stb(out_stb),
        .i_out_ack(out_ack));

    matmul_sequencer #(.N(1), .IDX_W(IW), .DW(DW)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .o_busy(busy1), .o_done(done1),
        .o_rd_en(rd_en1), .o_a_row(a_row1), .o_a_col(a_col1), .o_b_row(b_row1), .o_b_col(b_col1),
        .i_a_data(a_data1), .i_b_data(b_data1), .o_mac_a(mac_a1), .o_mac_b(mac_b1),
        .o_mac_first(mac_first1), .o_mac_last(mac_last1), .o_mac_stb(mac_stb1), .i_mac_ack(mac_ack1),
        .i_res_data(res_data1), .i_res_stb(res_stb1), .o_res_ack(res_ack1),
        .o_out_value(out_value1), .o_out_i(out_i1), .o_out_j(out_j1), .o_out_stb(out_stb1),
        .i_out_ack(out_ack1));

    always #5 clk = ~clk;

    int n_err, n_checks;
    int viol_mac, viol_out;
    logic [DW-1:0] ma [16][16];
    logic [DW-1:0] mb [16][16];
    term_t exp_terms[$], obs_terms[$];
    res_t  exp_res[$],   obs_res[$];

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    task automatic load_mats(input real a00, a01, a10, a11, b00, b01, b10, b11);
        ma[0][0] = r2f(a00); ma[0][1] = r2f(a01); ma[1][0] = r2f(a10); ma[1][1] = r2f(a11);
        mb[0][0] = r2f(b00); mb[0][1] = r2f(b01); mb[1][0] = r2f(b10); mb[1][1] = r2f(b11);
    endtask

    // Reference model: expected term stream and row-major result stream for an n x n product.
    task automatic push_expected(input int n);
        real acc;
        term_t t;
        res_t r;
        exp_terms.delete();
        exp_res.delete();
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                acc = 0.0;
                for (int k = 0; k < n; k++) begin
                    t.a = ma[i][k]; t.b = mb[k][j]; t.f = (k == 0); t.l = (k == n - 1);
                    exp_terms.push_back(t);
                    acc = acc + f2r(ma[i][k]) * f2r(mb[k][j]);
                end
                r.i = IW'(i); r.j = IW'(j); r.v = r2f(acc);
                exp_res.push_back(r);
            end
    endtask

    // Drives the N=2 instance through one multiply, acting as memory, MAC and writer.
    // Only records what it sees; the calling test does the comparisons.
    task automatic run_mm(input int mac_dly, input bit stall01, input bit abort_k1,
                          output int cyc, output bit tmo, output bit aborted);
        bit prd = 0, mprev = 0, mxfer = 0, oprev = 0, oxfer = 0;
        logic [IW-1:0] par = 0, pac = 0, pbr = 0, pbc = 0;
        int wcnt = 0, ocnt = 0;
        logic [2*DW+1:0] mcur, msave = '0;
        logic [DW+2*IW-1:0] ocur, osave = '0;
        real acc = 0.0, p;
        term_t t;
        res_t r;
        aborted = 0; viol_mac = 0; viol_out = 0;
        obs_terms.delete(); obs_res.delete();
        start = 1; @(posedge clk); #1; start = 0; cyc = 0;
        while (!done && cyc < 1000) begin
            a_data = prd ? ma[par[3:0]][pac[3:0]] : 32'hDEADBEEF;
            b_data = prd ? mb[pbr[3:0]][pbc[3:0]] : 32'hDEADBEEF;
            prd = rd_en; par = a_row; pac = a_col; pbr = b_row; pbc = b_col;
            if (abort_k1 && mac_stb && a_col == 1) begin
                mac_ack = 0; rst_n = 0;
                @(posedge clk); #1;
                rst_n = 1; aborted = 1;
                break;
            end
            mac_ack = (mac_dly == 0) || (mac_stb && wcnt >= mac_dly);
            wcnt = (mac_stb && !mac_ack) ? wcnt + 1 : 0;
            mcur = {mac_a, mac_b, mac_first, mac_last};
            if (mac_stb && mprev && mcur !== msave) viol_mac++;
            if (mac_stb && (rd_en || mxfer)) viol_mac++;
            msave = mcur; mprev = mac_stb && !mac_ack; mxfer = mac_stb && mac_ack;
            if (mac_stb && mac_ack) begin
                p = f2r(mac_a) * f2r(mac_b);
                acc = mac_first ? p : acc + p;
                t.a = mac_a; t.b = mac_b; t.f = mac_first; t.l = mac_last;
                obs_terms.push_back(t);
            end
            res_stb = 1; res_data = r2f(acc);
            if (out_stb) begin
                out_ack = !(stall01 && out_i == 0 && out_j == 1 && ocnt < 10);
                ocnt++;
            end else begin
                out_ack = 1; ocnt = 0;
            end
            ocur = {out_value, out_i, out_j};
            if (out_stb && oprev && ocur !== osave) viol_out++;
            if (out_stb && (rd_en || oxfer)) viol_out++;
            osave = ocur; oprev = out_stb && !out_ack; oxfer = out_stb && out_ack;
            if (out_stb && out_ack) begin
                r.i = out_i; r.j = out_j; r.v = out_value;
                obs_res.push_back(r);
            end
            @(posedge clk); #1; cyc++;
        end
        tmo = !done && !aborted;
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, rd_en, mac_stb, mac_first, mac_last, res_ack, out_stb} !== 8'd0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 00000000",
                {busy, done, rd_en, mac_stb, mac_first, mac_last, res_ack, out_stb});
        end
        n_checks++;
        if ({a_row, a_col, b_row, b_col, out_i, out_j} !== '0) begin
            n_err++; $display("FAIL reset_idx: got %h want 0", {a_row, a_col, b_row, b_col, out_i, out_j});
        end
        n_checks++;
        if ({mac_a, mac_b, out_value} !== '0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", {mac_a, mac_b, out_value});
        end
        rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, busy1, done1} !== 4'd0) begin
            n_err++; $display("FAIL idle_hold: got %b want 0000", {busy, done, busy1, done1});
        end
    endtask

    task automatic test_basic;
        int cyc; bit tmo, ab;
        logic [DW-1:0] ref_v [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        load_mats(1.0, 2.0, 3.0, 4.0, 1.0, 0.0, 0.0, 1.0);
        push_expected(2);
        run_mm(0, 0, 0, cyc, tmo, ab);
        n_checks++;
        if (tmo || cyc != 32) begin n_err++; $display("FAIL basic_cycles: got %0d (timeout %0d) want 32", cyc, tmo); end
        n_checks++;
        if (obs_terms.size() != exp_terms.size()) begin
            n_err++; $display("FAIL basic_nterms: got %0d want %0d", obs_terms.size(), exp_terms.size());
        end
        for (int n = 0; n < obs_terms.size() && n < exp_terms.size(); n++) begin
            n_checks++;
            if (obs_terms[n] != exp_terms[n]) begin
                n_err++; $display("FAIL basic_term%0d: got a=%h b=%h fl=%b%b want a=%h b=%h fl=%b%b", n,
                    obs_terms[n].a, obs_terms[n].b, obs_terms[n].f, obs_terms[n].l,
                    exp_terms[n].a, exp_terms[n].b, exp_terms[n].f, exp_terms[n].l);
            end
        end
        n_checks++;
        if (obs_res.size() != 4) begin n_err++; $display("FAIL basic_nres: got %0d want 4", obs_res.size()); end
        for (int n = 0; n < 4 && obs_res.size() > 0; n++) begin
            res_t e, o;
            e = exp_res.pop_front(); o = obs_res.pop_front();
            n_checks++;
            if (o.i !== e.i || o.j !== e.j || o.v !== ref_v[n]) begin
                n_err++; $display("FAIL basic_res%0d: got (%0d,%0d)=%h want (%0d,%0d)=%h", n,
                    o.i, o.j, o.v, e.i, e.j, ref_v[n]);
            end
        end
    endtask

    task automatic test_mac_stall;
        int cyc; bit tmo, ab;
        load_mats(1.5, 2.0, -1.0, 0.5, 2.0, 1.0, 0.25, 3.0);
        push_expected(2);
        run_mm(5, 0, 0, cyc, tmo, ab);
        n_checks++;
        if (tmo || cyc != 72) begin n_err++; $display("FAIL macstall_cycles: got %0d want 72", cyc); end
        n_checks++;
        if (viol_mac != 0) begin n_err++; $display("FAIL macstall_hold: got %0d violations want 0", viol_mac); end
        n_checks++;
        if (obs_terms.size() != 8) begin n_err++; $display("FAIL macstall_nterms: got %0d want 8", obs_terms.size()); end
        for (int n = 0; n < obs_terms.size() && n < exp_terms.size(); n++) begin
            n_checks++;
            if (obs_terms[n] != exp_terms[n]) begin
                n_err++; $display("FAIL macstall_term%0d: got a=%h b=%h want a=%h b=%h", n,
                    obs_terms[n].a, obs_terms[n].b, exp_terms[n].a, exp_terms[n].b);
            end
        end
        n_checks++;
        if (obs_res.size() != exp_res.size()) begin
            n_err++; $display("FAIL macstall_nres: got %0d want %0d", obs_res.size(), exp_res.size());
        end
        while (obs_res.size() > 0 && exp_res.size() > 0) begin
            res_t e, o;
            e = exp_res.pop_front(); o = obs_res.pop_front();
            n_checks++;
            if (o != e) begin
                n_err++; $display("FAIL macstall_res: got (%0d,%0d)=%h want (%0d,%0d)=%h", o.i, o.j, o.v, e.i, e.j, e.v);
            end
        end
    endtask

    task automatic test_out_stall;
        int cyc; bit tmo, ab;
        load_mats(0.5, -2.0, 3.0, 1.0, 4.0, 1.0, -1.0, 2.0);
        push_expected(2);
        run_mm(0, 1, 0, cyc, tmo, ab);
        n_checks++;
        if (tmo || cyc != 42) begin n_err++; $display("FAIL outstall_cycles: got %0d want 42", cyc); end
        n_checks++;
        if (viol_out != 0) begin n_err++; $display("FAIL outstall_hold: got %0d violations want 0", viol_out); end
        n_checks++;
        if (obs_res.size() != exp_res.size()) begin
            n_err++; $display("FAIL outstall_nres: got %0d want %0d", obs_res.size(), exp_res.size());
        end
        while (obs_res.size() > 0 && exp_res.size() > 0) begin
            res_t e, o;
            e = exp_res.pop_front(); o = obs_res.pop_front();
            n_checks++;
            if (o != e) begin
                n_err++; $display("FAIL outstall_res: got (%0d,%0d)=%h want (%0d,%0d)=%h", o.i, o.j, o.v, e.i, e.j, e.v);
            end
        end
    endtask

    task automatic test_reset_mid;
        int cyc; bit tmo, ab;
        load_mats(2.0, -1.0, 0.5, 4.0, 1.0, 2.0, 3.0, -0.5);
        run_mm(0, 0, 1, cyc, tmo, ab);
        n_checks++;
        if (ab !== 1'b1) begin n_err++; $display("FAIL midrst_reached: got %b want 1", ab); end
        n_checks++;
        if ({busy, done, rd_en, mac_stb, mac_first, mac_last, res_ack, out_stb} !== 8'd0) begin
            n_err++; $display("FAIL midrst_ctrl: got %b want 00000000",
                {busy, done, rd_en, mac_stb, mac_first, mac_last, res_ack, out_stb});
        end
        n_checks++;
        if ({a_row, a_col, b_row, b_col, mac_a, mac_b, out_value} !== '0) begin
            n_err++; $display("FAIL midrst_data: got %h want 0", {a_row, a_col, b_row, b_col, mac_a, mac_b, out_value});
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL midrst_idle: got %b want 00", {busy, done}); end
        push_expected(2);
        run_mm(0, 0, 0, cyc, tmo, ab);
        n_checks++;
        if (tmo || cyc != 32) begin n_err++; $display("FAIL midrst_cycles: got %0d want 32", cyc); end
        n_checks++;
        if (obs_res.size() != exp_res.size()) begin
            n_err++; $display("FAIL midrst_nres: got %0d want %0d", obs_res.size(), exp_res.size());
        end
        while (obs_res.size() > 0 && exp_res.size() > 0) begin
            res_t e, o;
            e = exp_res.pop_front(); o = obs_res.pop_front();
            n_checks++;
            if (o != e) begin
                n_err++; $display("FAIL midrst_res: got (%0d,%0d)=%h want (%0d,%0d)=%h", o.i, o.j, o.v, e.i, e.j, e.v);
            end
        end
    endtask

    task automatic test_n1;
        int cyc, nterm, nout;
        logic [1:0] fl;
        logic [DW-1:0] val, expv;
        a_data1 = r2f(2.0); b_data1 = r2f(3.0);
        expv = r2f(f2r(a_data1) * f2r(b_data1));
        res_data1 = expv; mac_ack1 = 1; res_stb1 = 1; out_ack1 = 1;
        for (int run = 0; run < 2; run++) begin
            if (run == 0) begin
                start1 = 1; @(posedge clk); #1; start1 = 0;
            end else begin
                n_checks++;
                if (done1 !== 1'b1) begin n_err++; $display("FAIL n1_done_held: got %b want 1", done1); end
                start1 = 1; @(posedge clk); #1; start1 = 0;
                n_checks++;
                if ({done1, busy1} !== 2'b01) begin n_err++; $display("FAIL n1_restart: got done,busy=%b want 01", {done1, busy1}); end
            end
            cyc = 0; nterm = 0; nout = 0; fl = 2'b00; val = '0;
            while (!done1 && cyc < 100) begin
                start1 = (cyc == 1);
                if (mac_stb1) begin nterm++; fl = {mac_first1, mac_last1}; end
                if (out_stb1) begin nout++; val = out_value1; end
                @(posedge clk); #1; cyc++;
            end
            start1 = 0;
            n_checks++;
            if (cyc != 5) begin n_err++; $display("FAIL n1_cycles run%0d: got %0d want 5", run, cyc); end
            n_checks++;
            if (nterm != 1 || fl !== 2'b11) begin
                n_err++; $display("FAIL n1_term run%0d: got %0d terms fl=%b want 1 terms fl=11", run, nterm, fl);
            end
            n_checks++;
            if (nout != 1 || val !== expv) begin
                n_err++; $display("FAIL n1_out run%0d: got %0d outs val=%h want 1 outs val=%h", run, nout, val, expv);
            end
            repeat (3) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        clk = 0; rst_n = 0; n_err = 0; n_checks = 0;
        start = 0; a_data = '0; b_data = '0; mac_ack = 0; res_data = '0; res_stb = 0; out_ack = 0;
        start1 = 0; a_data1 = '0; b_data1 = '0; mac_ack1 = 0; res_data1 = '0; res_stb1 = 0; out_ack1 = 0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin ma[r][c] = '0; mb[r][c] = '0; end
        test_reset;
        test_basic;
        test_mac_stall;
        test_out_stall;
        test_reset_mid;
        test_n1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
